// File: rtl/alu_seq_pkg.sv
// ALU operation sequencer: shared opcodes, FSM states and helpers.
// Optional statistics counters are built when ALU_SEQ_STATS_EN is defined.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_NOT  = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_NAND = 5'd13;
  localparam logic [4:0] OP_LAST = 5'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_muldiv(
    input logic [4:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable 4-bit down-counter; expire flags the last wait cycle.
// Counting stops at zero.
module alu_seq_timer
  import alu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       expire
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (value != 4'd0) begin
      value <= value - 4'd1;
    end
  end

  assign expire = (value == 4'd1);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time, holding operands until capture.
// Define ALU_SEQ_STATS_EN to add stat_ops / stat_errs counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULDIV_WAIT = 4,
  parameter int SIMPLE_WAIT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [4:0]          alu_sel,
  input  logic [2*DATA_W-1:0] alu_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   z_hi,
  output logic [DATA_W-1:0]   z_lo,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs,
`endif
  output logic                rsp_err
);

  localparam logic [3:0] MD_WAIT = 4'(MULDIV_WAIT);
  localparam logic [3:0] SM_WAIT = 4'(SIMPLE_WAIT);

  state_t     state;
  logic       accept;
  logic       bad_op;
  logic       err_pend;
  logic [3:0] wait_val;
  logic [3:0] tmr_value;
  logic       tmr_expire;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  assign bad_op = (req_op > OP_LAST) ||
                  ((req_op == OP_DIV) &&
                   (req_b == '0));

  // Errors take one wait cycle so every response lands at T+N.
  always_comb begin
    wait_val = SM_WAIT;
    if (bad_op)
      wait_val = 4'd1;
    else if (is_muldiv(req_op))
      wait_val = MD_WAIT;
  end

  alu_seq_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (wait_val),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      z_hi      <= '0;
      z_lo      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_sel  <= req_op;
            err_pend <= bad_op;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A zero count cannot occur; it only guards against a stuck WAIT.
          if (tmr_expire || tmr_value == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_pend;
            if (err_pend) begin
              z_hi <= '0;
              z_lo <= '0;
            end else begin
              z_hi <= alu_out[2*DATA_W-1:DATA_W];
              z_lo <= alu_out[DATA_W-1:0];
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ops  <= 16'd0;
      stat_errs <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      stat_ops <= stat_ops + 16'd1;
      if (rsp_err)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU on its outputs.
// Stats checks are compiled when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sel;
  logic [63:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        rsp_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_op_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .z_hi      (z_hi),
    .z_lo      (z_lo),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs),
`endif
    .rsp_err   (rsp_err)
  );

  // Behavioural ALU; division by zero returns a marker that must never be seen.
  always_comb begin
    alu_out = 64'd0;
    case (alu_sel)
      5'd0:  alu_out = {32'd0, alu_a + alu_b};
      5'd1:  alu_out = {32'd0, alu_a - alu_b};
      5'd2:  alu_out = {32'd0, alu_a} * {32'd0, alu_b};
      5'd3:  alu_out = (alu_b == 0) ? 64'hDEADBEEF_DEADBEEF :
                       {alu_a % alu_b, alu_a / alu_b};
      5'd4:  alu_out = {32'd0, alu_a & alu_b};
      5'd5:  alu_out = {32'd0, alu_a | alu_b};
      5'd6:  alu_out = {32'd0, alu_a << alu_b[4:0]};
      5'd7:  alu_out = {32'd0, alu_a >> alu_b[4:0]};
      5'd8:  alu_out = {32'd0, (alu_a << alu_b[4:0]) |
                        (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}))};
      5'd9:  alu_out = {32'd0, (alu_a >> alu_b[4:0]) |
                        (alu_a << (6'd32 - {1'b0, alu_b[4:0]}))};
      5'd10: alu_out = {32'd0, ~alu_a};
      5'd11: alu_out = {32'd0, alu_a ^ alu_b};
      5'd12: alu_out = {32'd0, ~(alu_a | alu_b)};
      5'd13: alu_out = {32'd0, ~(alu_a & alu_b)};
      default: alu_out = 64'hBAD0BAD0_BAD0BAD0;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_a     = 32'h5A5A5A5A;
    req_b     = 32'hA5A5A5A5;
    req_op    = 5'd1;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      chk("alu_a_hold", 64'(alu_a), 64'(v.a));
      chk("alu_b_hold", 64'(alu_b), 64'(v.b));
      chk("alu_sel_hold", 64'(alu_sel), 64'(v.op));
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    chk("z_hi", 64'(z_hi), 64'(v.hi));
    chk("z_lo", 64'(z_lo), 64'(v.lo));
    chk("rsp_err", 64'(rsp_err), 64'(v.err));
    @(posedge clock);
    #1;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    vec_t v;
    int n;
    vecs[0]  = '{5'd0,  32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1};
    vecs[1]  = '{5'd2,  32'h00010000, 32'h00010000,
                 32'd1, 32'd0, 1'b0, 4};
    vecs[2]  = '{5'd3,  32'd17, 32'd0, 32'd0, 32'd0, 1'b1, 1};
    vecs[3]  = '{5'd20, 32'd17, 32'd5, 32'd0, 32'd0, 1'b1, 1};
    vecs[4]  = '{5'd3,  32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 4};
    vecs[5]  = '{5'd1,  32'd5, 32'd7, 32'd0,
                 32'hFFFFFFFE, 1'b0, 1};
    vecs[6]  = '{5'd6,  32'd1, 32'd4, 32'd0, 32'd16, 1'b0, 1};
    vecs[7]  = '{5'd8,  32'h80000001, 32'd1, 32'd0,
                 32'h00000003, 1'b0, 1};
    vecs[8]  = '{5'd13, 32'hFFFF0000, 32'hFF00FF00, 32'd0,
                 32'h00FFFFFF, 1'b0, 1};
    vecs[9]  = '{5'd14, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 1};
    vecs[10] = '{5'd31, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1};
    vecs[11] = '{5'd2,  32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 1'b0, 4};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 5'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_z", {z_hi, z_lo}, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i]);

    // Backpressure: response held, competing request ignored.
    rsp_ready = 1'b0;
    v = '{5'd11, 32'hF0F0F0F0, 32'hFFFF0000, 32'd0,
          32'h0F0FF0F0, 1'b0, 1};
    @(negedge clock);
    req_valid = 1'b1;
    req_op = v.op;
    req_a = v.a;
    req_b = v.b;
    @(posedge clock);
    #1;
    req_op = 5'd0;
    req_a  = 32'd1;
    req_b  = 32'd1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bp_latency", 64'(n), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_z_lo", 64'(z_lo), 64'(v.lo));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_alu_sel", 64'(alu_sel), 64'd11);
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("bp_not_taken", 64'(alu_sel), 64'd11);
    chk("bp_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;

`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'd13);
    chk("stat_errs", 64'(stat_errs), 64'd4);
`endif

    // Asynchronous reset in the middle of a multiply wait.
    @(negedge clock);
    req_valid = 1'b1;
    req_op = 5'd2;
    req_a = 32'd3;
    req_b = 32'd4;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #3;
    chk("mid_alu_sel", 64'(alu_sel), 64'd2);
    reset = 1'b1;
    #1;
    chk("ar_alu_a", 64'(alu_a), 64'd0);
    chk("ar_alu_b", 64'(alu_b), 64'd0);
    chk("ar_alu_sel", 64'(alu_sel), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd1);
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("ar_stat_ops", 64'(stat_ops), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (rsp_valid) n++;
    end
    chk("ar_no_rsp", 64'(n), 64'd0);

    run_op(vecs[0]);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops_post", 64'(stat_ops), 64'd1);
    chk("stat_errs_post", 64'(stat_errs), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
